// File: rtl/cve2_sleep_ctrl_if.sv
// Signal bundle between the sleep controller and its environment.
// The controller uses the slave view; whatever drives the hart requests uses the master view.
interface cve2_sleep_ctrl_if #(
    parameter int NumHarts = 2,
    parameter int WakeSrcW = 4,
    parameter int WakeCntW = 16
);
    logic                         test_en_i;
    logic [NumHarts-1:0]          fetch_enable_i;
    logic [NumHarts-1:0]          core_busy_i;
    logic [NumHarts-1:0]          debug_req_i;
    logic [NumHarts-1:0]          irq_nm_i;
    logic [NumHarts*WakeSrcW-1:0] wake_i;
    logic [NumHarts*WakeSrcW-1:0] wake_mask_i;
    logic [NumHarts-1:0]          wake_cnt_clr_i;

    logic [NumHarts-1:0]          clk_en_o;
    logic [NumHarts-1:0]          fetch_enable_o;
    logic [NumHarts-1:0]          core_sleep_o;
    logic                         all_sleep_o;
    logic [NumHarts*WakeCntW-1:0] wake_cnt_o;

    modport master (
        output test_en_i, fetch_enable_i, core_busy_i, debug_req_i, irq_nm_i,
        output wake_i, wake_mask_i, wake_cnt_clr_i,
        input  clk_en_o, fetch_enable_o, core_sleep_o, all_sleep_o, wake_cnt_o
    );

    modport slave (
        input  test_en_i, fetch_enable_i, core_busy_i, debug_req_i, irq_nm_i,
        input  wake_i, wake_mask_i, wake_cnt_clr_i,
        output clk_en_o, fetch_enable_o, core_sleep_o, all_sleep_o, wake_cnt_o
    );
endinterface

// File: rtl/cve2_sleep_ctrl.sv
// Per-hart clock-gating controller: idles a hart after IdleDelay quiet cycles, wakes it
// combinationally on debug, NMI or unmasked wake sources, and counts wake-ups.
module cve2_sleep_ctrl #(
    parameter int NumHarts  = 2,
    parameter int WakeSrcW  = 4,
    parameter int IdleDelay = 4,
    parameter int WakeCntW  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    cve2_sleep_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_IDLE  = 2'd2,
        ST_SLEEP = 2'd3
    } state_e;

    localparam bit                ZeroDelay  = (IdleDelay == 0);
    localparam logic [7:0]        IdleLoad   = ZeroDelay ? 8'd0 : 8'(IdleDelay - 1);
    localparam logic [WakeCntW-1:0] WakeCntMax = {WakeCntW{1'b1}};

    logic [NumHarts-1:0] fetch_en_r;
    logic [NumHarts-1:0] busy_r;
    logic [NumHarts-1:0] fetch_live_s;
    logic [NumHarts-1:0] wake_any_s;
    logic [NumHarts-1:0] clk_en_int_s;
    logic [NumHarts-1:0] core_sleep_s;

    // Sticky fetch-enable latch and registered busy, shared by all per-hart FSMs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_en_r <= {NumHarts{1'b0}};
            busy_r     <= {NumHarts{1'b0}};
        end else begin
            fetch_en_r <= fetch_en_r | bus.fetch_enable_i;
            busy_r     <= bus.core_busy_i;
        end
    end

    // Masking with rst_i keeps every output at its reset value while reset is held.
    assign fetch_live_s = fetch_en_r & ~{NumHarts{rst_i}};

    for (genvar h = 0; h < NumHarts; h++) begin : g_hart
        state_e              state_r;
        state_e              state_nxt_s;
        logic [7:0]          idle_cnt_r;
        logic [7:0]          idle_cnt_nxt_s;
        logic [WakeCntW-1:0] wake_cnt_r;
        logic                wake_inc_s;

        assign wake_any_s[h] = bus.debug_req_i[h] | bus.irq_nm_i[h]
                             | (|(bus.wake_i[h*WakeSrcW +: WakeSrcW]
                                & bus.wake_mask_i[h*WakeSrcW +: WakeSrcW]));

        // Next-state, idle countdown and wake-event detection
        always_comb begin
            state_nxt_s    = state_r;
            idle_cnt_nxt_s = idle_cnt_r;
            wake_inc_s     = 1'b0;
            case (state_r)
                ST_OFF: begin
                    if (fetch_en_r[h]) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_OFF;
                    end
                end
                ST_RUN: begin
                    if (!busy_r[h] && !wake_any_s[h]) begin
                        if (ZeroDelay) begin
                            state_nxt_s = ST_SLEEP;
                        end else begin
                            state_nxt_s    = ST_IDLE;
                            idle_cnt_nxt_s = IdleLoad;
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_IDLE: begin
                    if (busy_r[h] || wake_any_s[h]) begin
                        state_nxt_s    = ST_RUN;
                        idle_cnt_nxt_s = 8'd0;
                    end else if (idle_cnt_r == 8'd0) begin
                        state_nxt_s = ST_SLEEP;
                    end else begin
                        idle_cnt_nxt_s = idle_cnt_r - 8'd1;
                    end
                end
                ST_SLEEP: begin
                    if (busy_r[h] || wake_any_s[h]) begin
                        state_nxt_s = ST_RUN;
                        wake_inc_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_SLEEP;
                    end
                end
                default: begin
                    state_nxt_s    = ST_OFF;
                    idle_cnt_nxt_s = 8'd0;
                end
            endcase
        end

        // State, idle counter and saturating wake counter (clear beats increment)
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_r    <= ST_OFF;
                idle_cnt_r <= 8'd0;
                wake_cnt_r <= {WakeCntW{1'b0}};
            end else begin
                state_r    <= state_nxt_s;
                idle_cnt_r <= idle_cnt_nxt_s;
                if (bus.wake_cnt_clr_i[h]) begin
                    wake_cnt_r <= {WakeCntW{1'b0}};
                end else if (wake_inc_s && (wake_cnt_r != WakeCntMax)) begin
                    wake_cnt_r <= wake_cnt_r + WakeCntW'(1);
                end else begin
                    wake_cnt_r <= wake_cnt_r;
                end
            end
        end

        // Wake sources bypass the FSM so the clock returns in the same cycle.
        assign clk_en_int_s[h] = fetch_live_s[h]
                               & ((state_r != ST_SLEEP) | wake_any_s[h] | busy_r[h]);
        assign bus.wake_cnt_o[h*WakeCntW +: WakeCntW] = rst_i ? {WakeCntW{1'b0}} : wake_cnt_r;
    end

    assign core_sleep_s       = fetch_live_s & ~clk_en_int_s;
    assign bus.clk_en_o       = clk_en_int_s | {NumHarts{bus.test_en_i}};
    assign bus.fetch_enable_o = fetch_live_s;
    assign bus.core_sleep_o   = core_sleep_s;
    assign bus.all_sleep_o    = &core_sleep_s;

endmodule
